hi_skid_reg: RTL

- Elastic pipeline register: the downstream-driven counterpart of the plain enable register used along bitonic mesh datapaths.
- A plain enable register only has a writer side. This block adds the reader side: a valid/ready handshake on both ports. The enable is generated internally from downstream acceptance, so backpressure can travel up a compare-exchange chain.
- Two-entry (main + skid) storage gives full throughput with a registered upstream ready, so there is no combinational ready path through the mesh.

---
 rtl/hi_skid_reg.sv | 77 +++++++
 1 files changed

// File: rtl/hi_skid_reg.sv
// hi_skid_reg: two-entry elastic register (main + skid) with a registered upstream ready.
// Define HI_SKID_FLUSH_EN to add a flush port that discards all stored words.
module hi_skid_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef HI_SKID_FLUSH_EN
    ,
    input  logic             flush
`endif
);
    logic             r_main_v;
    logic             r_skid_v;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_flush;
    logic             w_in_fire;
    logic             w_out_fire;
`ifdef HI_SKID_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif
    assign in_ready   = !r_skid_v && !reset && !w_flush;
    assign out_valid  = r_main_v;
    assign out_data   = r_main;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_main_v && out_ready;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main   <= '0;
            r_skid   <= '0;
        end else if (w_flush) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else begin
            case ({r_skid_v, r_main_v})
                2'b00: begin
                    if (w_in_fire) begin
                        r_main   <= in_data;
                        r_main_v <= 1'b1;
                    end
                end
                2'b01: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main <= in_data;
                    end else if (w_in_fire) begin
                        r_skid   <= in_data;
                        r_skid_v <= 1'b1;
                    end else if (w_out_fire) begin
                        r_main_v <= 1'b0;
                    end
                end
                2'b11: begin
                    if (w_out_fire) begin
                        r_main   <= r_skid;
                        r_skid_v <= 1'b0;
                    end
                end
                2'b10: begin
                    // skid without main cannot arise; recover to empty
                    r_skid_v <= 1'b0;
                    r_main_v <= 1'b0;
                end
            endcase
        end
    end
endmodule
